// File: rtl/fractal_sync_tgen.sv
// -----------------------------------------------------------------------------
// fractal_sync_tgen
//
// Traffic generator that drives the request side of a fractal sync network
// from N_PORTS independent compute-unit channels. A single start_i pulse
// launches one run. Each enabled channel waits a pseudo-random compute delay,
// issues one sync request, and then waits for its wake response or a timeout.
// When every channel has finished, done_o pulses and the run counter advances.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset
//   start_i        one-cycle pulse launching a run (ignored while busy_o)
//   port_en_i      per-channel enable, sampled at start
//   comp_cycles_i  per-channel base compute delay, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   rand_mask_i    mask applied to the LFSR jitter, sampled at start
//   aggr_i, id_i   request fields shared by all channels, sampled at start
//   req_sync_o     per-channel one-cycle sync request
//   req_aggr_o     per-channel aggregate field, zero while req_sync_o[i] is low
//   req_id_o       per-channel barrier id, zero while req_sync_o[i] is low
//   rsp_wake_i     per-channel wake response
//   rsp_error_i    per-channel error flag, meaningful together with wake
//   busy_o         run in progress (accepted start .. done_o inclusive)
//   done_o         one-cycle pulse when all channels have finished
//   error_o        sticky: a wake arrived with its error flag set
//   timeout_o      sticky: a channel gave up waiting for its wake
//   spurious_o     sticky: a response arrived on a channel not waiting for one
//   run_cnt_o      number of completed runs, wraps at 16 bits
//
// Cycle numbering used below: "cycle n" is the interval following the n-th
// rising edge after the edge that accepts start_i (that edge is edge 0).
// A channel with compute delay d enters COMP in cycle 0 and shows its request
// in cycle d+1.
// -----------------------------------------------------------------------------
module fractal_sync_tgen #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned AGGR_WIDTH = 6,
  parameter int unsigned ID_WIDTH   = 5,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned RAND_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [N_PORTS-1:0]               port_en_i,
  input  logic [N_PORTS*CNT_WIDTH-1:0]     comp_cycles_i,
  input  logic [RAND_WIDTH-1:0]            rand_mask_i,
  input  logic [AGGR_WIDTH-1:0]            aggr_i,
  input  logic [ID_WIDTH-1:0]              id_i,
  output logic [N_PORTS-1:0]               req_sync_o,
  output logic [N_PORTS*AGGR_WIDTH-1:0]    req_aggr_o,
  output logic [N_PORTS*ID_WIDTH-1:0]      req_id_o,
  input  logic [N_PORTS-1:0]               rsp_wake_i,
  input  logic [N_PORTS-1:0]               rsp_error_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic                             timeout_o,
  output logic                             spurious_o,
  output logic [15:0]                      run_cnt_o
);

  // Channel state machine.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMP,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Delay sums are one bit wider than the base delay so base + jitter never
  // wraps; the same register later counts WAIT cycles.
  localparam int unsigned   CW        = CNT_WIDTH + 1;
  // WAIT is entered with the counter at 1 (cycles since the request), so the
  // channel gives up on the edge where that count would reach TIMEOUT.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  // Per-channel LFSR seed; the all-zero lock-up state is never loaded.
  function automatic logic [15:0] lfsr_seed(input int idx);
    logic [15:0] s;
    s = LFSR_SEED + 16'(idx);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Channel state
  state_e                  r_state [N_PORTS];
  logic [CW-1:0]           r_cnt   [N_PORTS];
  logic [15:0]             r_lfsr  [N_PORTS];

  // Run-wide latched request fields
  logic [AGGR_WIDTH-1:0]   r_aggr;
  logic [ID_WIDTH-1:0]     r_id;

  // Registered outputs
  logic [N_PORTS-1:0]            r_req_sync;
  logic [N_PORTS*AGGR_WIDTH-1:0] r_req_aggr;
  logic [N_PORTS*ID_WIDTH-1:0]   r_req_id;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_error;
  logic                          r_timeout;
  logic                          r_spurious;
  logic [15:0]                   r_run_cnt;

  // Combinational helpers
  logic                    w_start_acc;
  logic                    w_all_done;
  logic [N_PORTS-1:0]      w_in_wait;
  logic [CW-1:0]           w_delay [N_PORTS];

  assign w_start_acc = start_i & ~r_busy;

  // NOTE: every signal driven here gets a value before any conditional use,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_all_done = 1'b1;
    w_in_wait  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_all_done   = w_all_done & (r_state[i] == ST_DONE);
      w_in_wait[i] = (r_state[i] == ST_WAIT);
      w_delay[i]   = CW'(comp_cycles_i[i*CNT_WIDTH +: CNT_WIDTH])
                   + CW'(r_lfsr[i][RAND_WIDTH-1:0] & rand_mask_i);
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // channel sees the pre-edge values of the shared flags it reads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the whole state is small, so everything is reset, including the
      // counters and the LFSRs; this is what makes a mid-run reset a clean abort.
      for (int i = 0; i < N_PORTS; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
        r_lfsr[i]  <= lfsr_seed(i);
      end
      r_aggr     <= '0;
      r_id       <= '0;
      r_req_sync <= '0;
      r_req_aggr <= '0;
      r_req_id   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_spurious <= 1'b0;
      r_run_cnt  <= '0;
    end else begin
      // Request outputs and done are pulses; default them low every cycle.
      r_done     <= 1'b0;
      r_req_sync <= '0;
      r_req_aggr <= '0;
      r_req_id   <= '0;

      // A response on a channel that is not waiting only raises the flag.
      if (|((rsp_wake_i | rsp_error_i) & ~w_in_wait)) begin
        r_spurious <= 1'b1;
      end

      // busy_o covers the done_o cycle and drops on the edge after it.
      if (w_start_acc) begin
        r_busy <= 1'b1;
        r_aggr <= aggr_i;
        r_id   <= id_i;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end

      // All channels finished: pulse done and count the run (16-bit wrap).
      if (w_all_done) begin
        r_done    <= 1'b1;
        r_run_cnt <= r_run_cnt + 16'd1;
      end

      for (int i = 0; i < N_PORTS; i++) begin
        r_lfsr[i] <= lfsr_next(r_lfsr[i]);

        case (r_state[i])
          ST_IDLE: begin
            if (w_start_acc) begin
              if (port_en_i[i]) begin
                r_state[i] <= ST_COMP;
                r_cnt[i]   <= w_delay[i];
              end else begin
                r_state[i] <= ST_DONE;
              end
            end
          end

          // The request is registered on the way into REQ so req_sync_o is
          // high exactly while the channel sits in REQ.
          ST_COMP: begin
            if (r_cnt[i] == '0) begin
              r_state[i]                            <= ST_REQ;
              r_req_sync[i]                         <= 1'b1;
              r_req_aggr[i*AGGR_WIDTH +: AGGR_WIDTH] <= r_aggr;
              r_req_id[i*ID_WIDTH +: ID_WIDTH]       <= r_id;
            end else begin
              r_cnt[i] <= r_cnt[i] - CW'(1);
            end
          end

          ST_REQ: begin
            r_state[i] <= ST_WAIT;
            r_cnt[i]   <= CW'(1);
          end

          // Wake is checked first, so a wake on the timeout edge wins.
          ST_WAIT: begin
            if (rsp_wake_i[i]) begin
              r_state[i] <= ST_DONE;
              if (rsp_error_i[i]) begin
                r_error <= 1'b1;
              end
            end else if (r_cnt[i] >= WAIT_LAST) begin
              r_state[i] <= ST_DONE;
              r_timeout  <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end

          ST_DONE: begin
            if (w_all_done) begin
              r_state[i] <= ST_IDLE;
            end
          end

          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_sync_o = r_req_sync;
  assign req_aggr_o = r_req_aggr;
  assign req_id_o   = r_req_id;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign timeout_o  = r_timeout;
  assign spurious_o = r_spurious;
  assign run_cnt_o  = r_run_cnt;

endmodule

// File: tb/tb_fractal_sync_tgen.sv
// -----------------------------------------------------------------------------
// tb_fractal_sync_tgen
//
// Directed bench for fractal_sync_tgen with default parameters (2 channels,
// TIMEOUT 1024). Inputs are driven and outputs sampled on the falling edge.
// Cycle n is the interval after the n-th rising edge following the edge that
// samples start_i (edge 0); start_i itself is high in the cycle before edge 0.
// A response "at edge e" is driven during cycle e-1 and sampled at edge e.
// -----------------------------------------------------------------------------
module tb_fractal_sync_tgen;

  localparam int NP = 2;
  localparam int AW = 6;
  localparam int IW = 5;
  localparam int CW = 16;
  localparam int RW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [NP-1:0]     port_en_i = '0;
  logic [NP*CW-1:0]  comp_cycles_i = '0;
  logic [RW-1:0]     rand_mask_i = '0;
  logic [AW-1:0]     aggr_i = '0;
  logic [IW-1:0]     id_i = '0;
  logic [NP-1:0]     req_sync_o;
  logic [NP*AW-1:0]  req_aggr_o;
  logic [NP*IW-1:0]  req_id_o;
  logic [NP-1:0]     rsp_wake_i = '0;
  logic [NP-1:0]     rsp_error_i = '0;
  logic              busy_o, done_o, error_o, timeout_o, spurious_o;
  logic [15:0]       run_cnt_o;

  fractal_sync_tgen dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .port_en_i     (port_en_i),
    .comp_cycles_i (comp_cycles_i),
    .rand_mask_i   (rand_mask_i),
    .aggr_i        (aggr_i),
    .id_i          (id_i),
    .req_sync_o    (req_sync_o),
    .req_aggr_o    (req_aggr_o),
    .req_id_o      (req_id_o),
    .rsp_wake_i    (rsp_wake_i),
    .rsp_error_i   (rsp_error_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o),
    .spurious_o    (spurious_o),
    .run_cnt_o     (run_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Results of the most recent run
  int req_cyc [NP];
  int req_n   [NP];
  int done_cyc;
  int done_n;
  int to_cyc;
  bit field_bad;
  bit busy_done;
  bit busy_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Launch one run and watch it. w0/w1: wake edges (-1 none); e0: error with
  // channel 0 wake; s1: extra wake edge on channel 1; rs: repeated start edge;
  // auto_w: wake each channel two edges after its request shows.
  task automatic run(input int w0, input int w1, input bit e0, input int s1,
                     input int rs, input bit auto_w, input int maxc);
    int cyc;
    int stop_at;
    for (int c = 0; c < NP; c++) begin
      req_cyc[c] = -1;
      req_n[c]   = 0;
    end
    done_cyc   = -1;
    done_n     = 0;
    to_cyc     = -1;
    field_bad  = 1'b0;
    busy_done  = 1'b0;
    busy_after = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc     = 0;
    stop_at = maxc;
    while (cyc < stop_at) begin
      for (int c = 0; c < NP; c++) begin
        if (req_sync_o[c]) begin
          req_n[c]++;
          if (req_cyc[c] < 0) req_cyc[c] = cyc;
          if (req_aggr_o[c*AW +: AW] !== aggr_i || req_id_o[c*IW +: IW] !== id_i) field_bad = 1'b1;
          if (auto_w) begin
            if (c == 0) w0 = cyc + 2;
            else        w1 = cyc + 2;
          end
        end else if (req_aggr_o[c*AW +: AW] !== '0 || req_id_o[c*IW +: IW] !== '0) begin
          field_bad = 1'b1;
        end
      end
      if (timeout_o === 1'b1 && to_cyc < 0) to_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy_o;
      if (done_o === 1'b1) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          busy_done = busy_o;
          stop_at   = cyc + 3;
        end
      end
      rsp_wake_i[0]  = (cyc + 1 == w0);
      rsp_wake_i[1]  = (cyc + 1 == w1) || (cyc + 1 == s1);
      rsp_error_i[0] = e0 && (cyc + 1 == w0);
      rsp_error_i[1] = 1'b0;
      start_i        = (cyc + 1 == rs);
      @(negedge clk_i);
      cyc++;
    end
    rsp_wake_i  = '0;
    rsp_error_i = '0;
    start_i     = 1'b0;
  endtask

  initial begin
    int pulses;

    // Reset state
    do_reset();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_status", {error_o, timeout_o, spurious_o}, 0);
    check("rst_run_cnt", run_cnt_o, 0);
    check("rst_req", {req_sync_o, req_aggr_o, req_id_o}, 0);

    // comp 10/20, no jitter, wake both at edge 25
    port_en_i     = 2'b11;
    comp_cycles_i = {16'd20, 16'd10};
    rand_mask_i   = '0;
    aggr_i        = 6'h15;
    id_i          = 5'h0A;
    run(25, 25, 0, -1, -1, 0, 60);
    check("a_req0_cyc", req_cyc[0], 11);
    check("a_req1_cyc", req_cyc[1], 21);
    check("a_req_pulses", {req_n[0][15:0], req_n[1][15:0]}, {16'd1, 16'd1});
    check("a_fields", field_bad, 0);
    check("a_done_cyc", done_cyc, 26);
    check("a_done_width", done_n, 1);
    check("a_busy_at_done", busy_done, 1);
    check("a_busy_after", busy_after, 0);
    check("a_run_cnt", run_cnt_o, 1);
    check("a_status", {error_o, timeout_o, spurious_o}, 0);

    // comp 0, channel 1 disabled, start repeated at edge 3 while busy
    port_en_i     = 2'b01;
    comp_cycles_i = '0;
    aggr_i        = 6'h2C;
    id_i          = 5'h13;
    run(5, -1, 0, -1, 3, 0, 40);
    check("b_req0_cyc", req_cyc[0], 1);
    check("b_req0_n", req_n[0], 1);
    check("b_req1_n", req_n[1], 0);
    check("b_fields", field_bad, 0);
    check("b_done_cyc", done_cyc, 6);
    check("b_run_cnt", run_cnt_o, 2);
    check("b_spurious", spurious_o, 0);

    // No channel enabled: done with no requests
    port_en_i = 2'b00;
    run(-1, -1, 0, -1, -1, 0, 20);
    check("c_done_cyc", done_cyc, 1);
    check("c_req_n", req_n[0] + req_n[1], 0);
    check("c_run_cnt", run_cnt_o, 3);

    // Channel 1 never woken: timeout 1024 cycles after its request (cycle 1)
    port_en_i = 2'b11;
    run(5, -1, 0, -1, -1, 0, 1100);
    check("d_req1_cyc", req_cyc[1], 1);
    check("d_timeout_cyc", to_cyc, 1025);
    check("d_done_cyc", done_cyc, 1026);
    check("d_timeout", timeout_o, 1);
    check("d_error", error_o, 0);

    // Wake on exactly the timeout edge counts as a wake
    do_reset();
    run(5, 1025, 0, -1, -1, 0, 1100);
    check("e_timeout_cyc", to_cyc, -1);
    check("e_done_cyc", done_cyc, 1026);
    check("e_timeout", timeout_o, 0);

    // Error wake on channel 0, spurious wake on channel 1 during COMP
    comp_cycles_i = {16'd10, 16'd5};
    run(10, 15, 1, 3, -1, 0, 60);
    check("f_req0_cyc", req_cyc[0], 6);
    check("f_req1_cyc", req_cyc[1], 11);
    check("f_req1_n", req_n[1], 1);
    check("f_done_cyc", done_cyc, 16);
    check("f_error", error_o, 1);
    check("f_spurious", spurious_o, 1);
    check("f_timeout", timeout_o, 0);

    // Sticky flags survive a clean run
    comp_cycles_i = '0;
    run(3, 3, 0, -1, -1, 0, 30);
    check("g_done_cyc", done_cyc, 4);
    check("g_sticky", {error_o, spurious_o}, 2'b11);

    // Reset mid-run while channel 0 computes; responses during reset ignored
    comp_cycles_i = {16'd20, 16'd20};
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_ni     = 1'b0;
    rsp_wake_i = 2'b11;
    @(negedge clk_i);
    rst_ni     = 1'b1;
    rsp_wake_i = '0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (req_sync_o !== '0) pulses++;
      @(negedge clk_i);
    end
    check("h_no_req", pulses, 0);
    check("h_status", {busy_o, done_o, error_o, timeout_o, spurious_o}, 0);
    check("h_run_cnt", run_cnt_o, 0);
    comp_cycles_i = {16'd3, 16'd2};
    run(6, 6, 0, -1, -1, 0, 40);
    check("h_req_cyc", {req_cyc[0][15:0], req_cyc[1][15:0]}, {16'd3, 16'd4});
    check("h_done_cyc", done_cyc, 7);
    check("h_run_cnt2", run_cnt_o, 1);

    // Full jitter, ten runs: request within [comp+1, comp+16] cycles
    do_reset();
    comp_cycles_i = {16'd4, 16'd10};
    rand_mask_i   = 4'hF;
    aggr_i        = 6'd1;
    id_i          = 5'd0;
    for (int r = 0; r < 10; r++) begin
      run(-1, -1, 0, -1, -1, 1, 200);
      check($sformatf("j_range0_%0d", r), (req_cyc[0] >= 11 && req_cyc[0] <= 26), 1);
      check($sformatf("j_range1_%0d", r), (req_cyc[1] >= 5 && req_cyc[1] <= 20), 1);
      check($sformatf("j_done_%0d", r), (done_n == 1 && !field_bad), 1);
      check($sformatf("j_nox_%0d", r),
            $isunknown({req_sync_o, req_aggr_o, req_id_o, busy_o, done_o,
                        error_o, timeout_o, spurious_o, run_cnt_o}), 0);
    end
    check("j_run_cnt", run_cnt_o, 10);
    check("j_status", {error_o, timeout_o, spurious_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fractal_sync_tgen.md
FRACTAL_SYNC_TGEN -- requirements
Module: fractal_sync_tgen

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of independent CU sync channels (1..16).
REQ-002 SHALL have parameter AGGR_WIDTH, default 6, aggregate field width.
REQ-003 SHALL have parameter ID_WIDTH, default 5, barrier id field width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, compute-delay counter width.
REQ-005 SHALL have parameter RAND_WIDTH, default 4, random jitter width (<=16).
REQ-006 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles before timeout (>=1, < 2^CNT_WIDTH).
REQ-007 SHALL have parameter LFSR_SEED, default 16'hACE1, base LFSR seed.
REQ-008 SHALL have port clk_i, input, 1, single clock; all logic is rising-edge.
REQ-009 SHALL have port rst_ni, input, 1, reset, synchronous, active-low.
REQ-010 SHALL have port start_i, input, 1, single-cycle pulse that launches one run.
REQ-011 SHALL have port port_en_i, input, N_PORTS, per-channel enable, sampled at start.
REQ-012 SHALL have port comp_cycles_i, input, N_PORTS x CNT_WIDTH, per-channel base compute delay, sampled at start.
REQ-013 SHALL have port rand_mask_i, input, RAND_WIDTH, jitter mask, sampled at start.
REQ-014 SHALL have port aggr_i / id_i, input, AGGR_WIDTH / ID_WIDTH, request fields common to all channels, sampled at start.
REQ-015 SHALL have port req_sync_o, output, N_PORTS, per-channel sync request pulse.
REQ-016 SHALL have port req_aggr_o / req_id_o, output, N_PORTS x AGGR_WIDTH / N_PORTS x ID_WIDTH, request fields, valid when req_sync_o high.
REQ-017 SHALL have port rsp_wake_i / rsp_error_i, input, N_PORTS each, per-channel wake and error response.
REQ-018 SHALL have port busy_o, done_o, error_o, timeout_o, spurious_o, output, 1 each, status.
REQ-019 SHALL have port run_cnt_o, output, 16, count of completed runs.

Function
REQ-020 SHALL implement per channel FSM IDLE -> COMP -> REQ -> WAIT -> DONE.
REQ-021 In IDLE, on start_i with busy_o low, SHALL latch inputs; enabled channels enter COMP next cycle, disabled channels enter DONE directly.
REQ-022 start_i while busy_o high SHALL be ignored with no state change.
REQ-023 Per channel, SHALL run a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) seeded LFSR_SEED+i, stepping every cycle, never zero.
REQ-024 On COMP entry, delay SHALL be comp_cycles + (lfsr[RAND_WIDTH-1:0] & rand_mask), summed at CNT_WIDTH+1 bits with no wrap.
REQ-025 COMP SHALL count down the delay one per cycle; delay 0 enters REQ the cycle after COMP entry.
REQ-026 In REQ, req_sync_o[i] SHALL be high exactly one cycle with latched aggr/id; next state WAIT.
REQ-027 req_aggr_o/req_id_o SHALL be zero when req_sync_o[i] is low.
REQ-028 In WAIT, rsp_wake_i[i] SHALL move the channel to DONE; rsp_error_i[i] with wake SHALL also set error_o.
REQ-029 In WAIT, a wake arriving the cycle the counter reaches TIMEOUT SHALL be taken as wake, not timeout.
REQ-030 In WAIT, after TIMEOUT cycles without wake, SHALL move to DONE and set timeout_o.
REQ-031 rsp_wake_i[i] or rsp_error_i[i] while channel i is not in WAIT SHALL set spurious_o and be otherwise ignored.
REQ-032 When all channels are in DONE, SHALL pulse done_o for one cycle, return all channels to IDLE next cycle, increment run_cnt_o (wrapping 16'hFFFF -> 0).
REQ-033 busy_o SHALL be high from the cycle after accepted start_i up to and including the done_o cycle.
REQ-034 error_o, timeout_o, spurious_o SHALL be sticky until reset.
REQ-035 start_i with port_en_i all zero SHALL produce done_o two cycles after start_i, no requests.

Reset
REQ-036 With rst_ni low at a rising edge: all FSMs IDLE, counters 0, LFSRs reseeded, all outputs 0, run_cnt_o 0.
REQ-037 Reset mid-run SHALL abort all channels with no further req_sync_o pulses; responses during reset SHALL be ignored.

Verification
REQ-038 N_PORTS=2, comp=10/20, mask=0, start at cycle 0 -> req_sync_o[0] at cycle 11, [1] at cycle 21; wake both at cycle 25 -> done_o cycle 26, run_cnt_o=1.
REQ-039 comp=0, mask=0 -> req_sync_o at cycle 1 after start; start_i repeated at cycle 3 while busy -> ignored, one request only.
REQ-040 No wake on channel 1, TIMEOUT=1024 -> channel 1 DONE 1024 cycles after its request, timeout_o=1, done_o asserted.
REQ-041 Wake with error on channel 0 -> error_o=1 sticky; wake on channel 1 while in COMP -> spurious_o=1, channel 1 still issues its request.
REQ-042 rst_ni low for one edge while channel 0 in COMP -> no req_sync_o afterwards, all status 0, new start runs normally.
REQ-043 mask=4'hF, 10 runs of aggr=1, id=0 -> each delay within [comp, comp+15], run_cnt_o=10, no X on outputs.
